core_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I core. Drives the fetch → decode → execute → memory → writeback sequence around the instruction decoder, ALU, register file and CSR file.
- Owns the single shared memory port handshake, the PC/IR/register-file/CSR write strobes, the retired-instruction counter, and the halt-on-error logic.
- Consumes the decoder's classified control outputs; contains no datapath.

---
 rtl/core_sequencer.sv | 165 ++++++++++++++++
 tb/tb_core_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/execute/memory/writeback control FSM
// for the RV32I core. Owns the memory handshake, the datapath write strobes,
// the retired-instruction counter and the sticky halt-on-error flags.
module core_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned INSTRET_W   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 dec_mem_rd,
  input  logic                 dec_mem_wr,
  input  logic                 dec_r_we,
  input  logic                 dec_csr_we,
  input  logic                 dec_illegal,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_we,
  output logic                 rf_we,
  output logic                 csr_we,
  output logic                 pc_we,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic                 bus_err,
  output logic                 illegal
);

  localparam int unsigned WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 32'd1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_fetch_issued;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [INSTRET_W-1:0]  r_instret;
  logic                  r_bus_err;
  logic                  r_illegal;

  logic w_req;
  logic w_we;
  logic w_addr_sel;
  logic w_ir_we;
  logic w_rf_we;
  logic w_csr_we;
  logic w_pc_we;
  logic w_wait;
  logic w_timeout;

  // Strobes decoded from the current state and handshake inputs; forced low in reset
  always_comb begin
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_addr_sel = 1'b0;
    w_ir_we    = 1'b0;
    w_rf_we    = 1'b0;
    w_csr_we   = 1'b0;
    w_pc_we    = 1'b0;
    case (r_state)
      S_FETCH: begin
        // once the fetch has gone out, stall can no longer retract it
        w_req   = ~stall | r_fetch_issued;
        w_ir_we = w_req & mem_ready;
      end
      S_MEM: begin
        w_req      = 1'b1;
        w_addr_sel = 1'b1;
        w_we       = dec_mem_wr;
        w_pc_we    = mem_ready & dec_mem_wr;
      end
      S_WB: begin
        w_rf_we  = dec_r_we;
        w_csr_we = dec_csr_we;
        w_pc_we  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      w_req      = 1'b0;
      w_we       = 1'b0;
      w_addr_sel = 1'b0;
      w_ir_we    = 1'b0;
      w_rf_we    = 1'b0;
      w_csr_we   = 1'b0;
      w_pc_we    = 1'b0;
    end
    w_wait    = w_req & ~mem_ready;
    // a ready arriving on the last allowed cycle beats the timeout
    w_timeout = w_wait & (r_wait_cnt == WAIT_LAST);
  end

  // Sequencer state, wait counter, retired count and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_FETCH;
      r_fetch_issued <= 1'b0;
      r_wait_cnt     <= '0;
      r_instret      <= '0;
      r_bus_err      <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      r_fetch_issued <= (r_state == S_FETCH) & w_wait & ~w_timeout;
      r_wait_cnt     <= w_wait ? r_wait_cnt + WAIT_W'(1) : '0;
      if (w_pc_we) begin
        r_instret <= r_instret + INSTRET_W'(1);
      end
      case (r_state)
        S_FETCH: begin
          if (w_timeout) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end else if (w_ir_we) begin
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (dec_illegal) begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end else if (dec_mem_rd | dec_mem_wr) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (w_timeout) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end else if (mem_ready) begin
            r_state <= dec_mem_wr ? S_FETCH : S_WB;
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign mem_req      = w_req;
  assign mem_we       = w_we;
  assign mem_addr_sel = w_addr_sel;
  assign ir_we        = w_ir_we;
  assign rf_we        = w_rf_we;
  assign csr_we       = w_csr_we;
  assign pc_we        = w_pc_we;
  assign state        = r_state;
  assign instret      = r_instret;
  assign halted       = (r_state == S_HALT);
  assign bus_err      = r_bus_err;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with a short timeout and a narrow
// retired-instruction counter so the timeout and wrap cases are quick to reach.
module tb_core_sequencer;

  localparam int unsigned TO = 4;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          dec_mem_rd;
  logic          dec_mem_wr;
  logic          dec_r_we;
  logic          dec_csr_we;
  logic          dec_illegal;
  logic          mem_ready;
  logic          mem_req;
  logic          mem_we;
  logic          mem_addr_sel;
  logic          ir_we;
  logic          rf_we;
  logic          csr_we;
  logic          pc_we;
  logic [2:0]    state;
  logic [IW-1:0] instret;
  logic          halted;
  logic          bus_err;
  logic          illegal;

  int n_cmp = 0;
  int n_err = 0;

  core_sequencer #(.MEM_TIMEOUT(TO), .INSTRET_W(IW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_r_we(dec_r_we),
    .dec_csr_we(dec_csr_we), .dec_illegal(dec_illegal), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .rf_we(rf_we), .csr_we(csr_we), .pc_we(pc_we),
    .state(state), .instret(instret), .halted(halted),
    .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input int i, input logic [2:0] st,
                         input logic req, input logic ir, input logic pc, input logic rf);
    chk($sformatf("%s[%0d].state", tag, i), 64'(state), 64'(st));
    chk($sformatf("%s[%0d].mem_req", tag, i), 64'(mem_req), 64'(req));
    chk($sformatf("%s[%0d].ir_we", tag, i), 64'(ir_we), 64'(ir));
    chk($sformatf("%s[%0d].pc_we", tag, i), 64'(pc_we), 64'(pc));
    chk($sformatf("%s[%0d].rf_we", tag, i), 64'(rf_we), 64'(rf));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  logic       ld_rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [2:0] ld_st  [10] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};

  initial begin
    logic [2:0] es;
    rst = 1'b1; stall = 1'b0; mem_ready = 1'b1;
    dec_mem_rd = 1'b0; dec_mem_wr = 1'b0; dec_r_we = 1'b0;
    dec_csr_we = 1'b0; dec_illegal = 1'b0;
    #1;
    // reset values
    chk("rst.state", 64'(state), 64'd0);
    chk("rst.mem_req", 64'(mem_req), 64'd0);
    chk("rst.ir_we", 64'(ir_we), 64'd0);
    chk("rst.instret", 64'(instret), 64'd0);
    chk("rst.bus_err", 64'(bus_err), 64'd0);
    chk("rst.illegal", 64'(illegal), 64'd0);
    chk("rst.halted", 64'(halted), 64'd0);
    adv();
    rst = 1'b0;

    // ALU stream with zero-wait memory
    dec_r_we = 1'b1;
    for (int i = 0; i < 12; i++) begin
      es = (i % 4 == 3) ? 3'd4 : 3'(i % 4);
      #1;
      chk_cyc("addi", i, es, i % 4 == 0, i % 4 == 0, i % 4 == 3, i % 4 == 3);
      adv();
    end
    #1;
    chk("addi.instret", 64'(instret), 64'd3);

    // load: 2 fetch waits, 3 data waits
    dec_mem_rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ready = ld_rdy[i];
      #1;
      chk_cyc("load", i, ld_st[i], ld_st[i] == 3'd0 || ld_st[i] == 3'd3, i == 2, i == 9, i == 9);
      if (ld_st[i] == 3'd3) begin
        chk($sformatf("load[%0d].addr_sel", i), 64'(mem_addr_sel), 64'd1);
        chk($sformatf("load[%0d].mem_we", i), 64'(mem_we), 64'd0);
      end
      adv();
    end
    mem_ready = 1'b1;
    #1;
    chk("load.done_state", 64'(state), 64'd0);
    chk("load.instret", 64'(instret), 64'd4);

    // store with both rd and wr decoded
    dec_mem_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_cyc("store", i, 3'(i), i == 0 || i == 3, i == 0, i == 3, 1'b0);
      chk($sformatf("store[%0d].mem_we", i), 64'(mem_we), 64'(i == 3));
      adv();
    end
    #1;
    chk("store.no_wb", 64'(state), 64'd0);
    chk("store.instret", 64'(instret), 64'd5);

    // stall before fetch, then stall ignored after issue
    dec_mem_rd = 1'b0; dec_mem_wr = 1'b0; dec_csr_we = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_cyc("stall", i, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      adv();
    end
    stall = 1'b0; mem_ready = 1'b0;
    #1;
    chk("stall.issue_req", 64'(mem_req), 64'd1);
    adv();
    stall = 1'b1; mem_ready = 1'b1;
    #1;
    chk("stall.ignored_req", 64'(mem_req), 64'd1);
    chk("stall.ignored_ir", 64'(ir_we), 64'd1);
    adv();
    #1; chk("stall.decode", 64'(state), 64'd1);
    adv();
    #1; chk("stall.exec", 64'(state), 64'd2);
    adv();
    #1;
    chk_cyc("stall_wb", 0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("stall_wb.csr_we", 64'(csr_we), 64'd1);
    adv();
    #1;
    chk("stall.refetch_blocked", 64'(mem_req), 64'd0);
    chk("stall.instret", 64'(instret), 64'd6);
    stall = 1'b0; dec_csr_we = 1'b0;

    // ready arrives on the last allowed wait cycle: no error
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk_cyc("edge_rdy", i, 3'd0, 1'b1, i == 3, 1'b0, 1'b0);
      adv();
    end
    #1;
    chk("edge_rdy.decode", 64'(state), 64'd1);
    chk("edge_rdy.bus_err", 64'(bus_err), 64'd0);
    adv(); adv(); adv();
    #1;
    chk("edge_rdy.instret", 64'(instret), 64'd7);

    // reset while a data request is outstanding
    dec_mem_rd = 1'b1;
    adv(); adv(); adv();
    mem_ready = 1'b0;
    #1;
    chk("midmem.state", 64'(state), 64'd3);
    chk("midmem.req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("midmem.req_drop", 64'(mem_req), 64'd0);
    chk("midmem.state_rst", 64'(state), 64'd0);
    chk("midmem.instret_rst", 64'(instret), 64'd0);
    adv();
    rst = 1'b0; dec_mem_rd = 1'b0; mem_ready = 1'b1;

    // one retirement then an illegal instruction
    adv(); adv(); adv(); adv();
    #1;
    chk("ill.pre_instret", 64'(instret), 64'd1);
    dec_illegal = 1'b1;
    adv(); adv();
    #1;
    chk_cyc("ill_exec", 0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    adv();
    #1;
    chk_cyc("ill_halt", 0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ill.illegal", 64'(illegal), 64'd1);
    chk("ill.halted", 64'(halted), 64'd1);
    chk("ill.instret", 64'(instret), 64'd1);
    adv();
    #1;
    chk_cyc("ill_halt", 1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("ill.flag_clr", 64'(illegal), 64'd0);
    chk("ill.halted_clr", 64'(halted), 64'd0);
    adv();
    rst = 1'b0; dec_illegal = 1'b0;

    // fetch timeout
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_cyc("tmo", i, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      adv();
    end
    #1;
    chk("tmo.state", 64'(state), 64'd5);
    chk("tmo.bus_err", 64'(bus_err), 64'd1);
    chk("tmo.req", 64'(mem_req), 64'd0);
    chk("tmo.halted", 64'(halted), 64'd1);
    adv();
    #1;
    chk("tmo.sticky", 64'(bus_err), 64'd1);
    rst = 1'b1;
    #1;
    chk("tmo.clr", 64'(bus_err), 64'd0);
    adv();
    rst = 1'b0; mem_ready = 1'b1;

    // 16 retirements wrap the 4-bit counter
    dec_r_we = 1'b1;
    for (int r = 0; r < 16; r++) begin
      adv(); adv(); adv(); adv();
      if (r == 14) begin
        #1;
        chk("wrap.fifteen", 64'(instret), 64'd15);
      end
    end
    #1;
    chk("wrap.zero", 64'(instret), 64'd0);
    chk("wrap.state", 64'(state), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
